// File: rtl/spike_rate_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spike_rate_monitor: windowed spike counter with FWFT result FIFO;        |
// | optional per-window peak u tracking via `define PEAK_U_EN.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module spike_rate_monitor #(
  parameter int CNT_W      = 8,
  parameter int WIN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic [2:0]       u_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic [2:0]       out_peak_u,
  output logic             drop_pulse,
  output logic             busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state;
  logic [WIN_W-1:0] remain;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] mem_cnt [FIFO_DEPTH];
  logic             mem_sat [FIFO_DEPTH];

  assign win_load  = (window_len == '0) ? WIN_W'(1) : window_len;
  assign count_nxt = (spike_in && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
  assign sat_nxt   = sat | (spike_in && (count == CNT_MAX));

  // The push carries the last cycle's sample folded in (count_nxt/sat_nxt).
  assign push       = (state == COUNT) && enable && (remain == WIN_W'(1));
  assign out_valid  = (occ != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (occ == OCC_W'(FIFO_DEPTH));
  assign push_ok    = push && (!full || pop);
  assign drop_pulse = push && full && !pop && !reset;
  assign busy       = (state == COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      remain <= '0;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= COUNT;
            remain <= win_load;
            count  <= '0;
            sat    <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (remain == WIN_W'(1)) begin
            remain <= win_load;
            count  <= '0;
            sat    <= 1'b0;
          end else begin
            remain <= remain - WIN_W'(1);
            count  <= count_nxt;
            sat    <= sat_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push_ok) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_cnt[wr_ptr] <= count_nxt;
      mem_sat[wr_ptr] <= sat_nxt;
    end
  end

  assign out_count = out_valid ? mem_cnt[rd_ptr] : '0;
  assign out_sat   = out_valid ? mem_sat[rd_ptr] : 1'b0;

`ifdef PEAK_U_EN
  logic [2:0] peak;
  logic [2:0] peak_nxt;
  logic [2:0] mem_peak [FIFO_DEPTH];

  assign peak_nxt = (u_in > peak) ? u_in : peak;

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) begin
      peak <= 3'd0;
    end else if (enable) begin
      peak <= (remain == WIN_W'(1)) ? 3'd0 : peak_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_peak[wr_ptr] <= peak_nxt;
  end

  assign out_peak_u = out_valid ? mem_peak[rd_ptr] : 3'd0;
`else
  logic unused_u;
  assign unused_u   = ^u_in;
  assign out_peak_u = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spike_rate_monitor: directed + random bench with window-level model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spike_rate_monitor;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             spike_in;
  logic [2:0]       u_in;
  logic             enable;
  logic [WIN_W-1:0] window_len;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic [2:0]       out_peak_u;
  logic             drop_pulse;
  logic             busy;

  always #5 clk = ~clk;

  spike_rate_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .u_in(u_in), .enable(enable),
    .window_len(window_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_sat(out_sat), .out_peak_u(out_peak_u),
    .drop_pulse(drop_pulse), .busy(busy)
  );

  typedef struct {int cnt; int sat; int peak;} entry_t;

  entry_t q[$];
  bit     active = 0;
  int     left = 0, sum = 0, pk = 0;
  int     errors = 0, checks = 0, drops_seen = 0;
  bit     chk_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance model and DUT.
  task automatic cycle(input bit rst, input bit spk, input logic [2:0] u, input bit en, input bit rdy);
    bit     pop, push, drop;
    entry_t e, h;
    int     maxc, ev, ec, es, ep;
    reset = rst; spike_in = spk; u_in = u; enable = en; out_ready = rdy;
    #1;
    ev = (q.size() > 0) ? 1 : 0;
    ec = 0; es = 0; ep = 0;
    if (ev == 1) begin
      h = q[0];
      ec = h.cnt; es = h.sat;
`ifdef PEAK_U_EN
      ep = h.peak;
`endif
    end
    if (chk_on) begin
      chk("out_valid", out_valid, ev);
      chk("out_count", out_count, ec);
      chk("out_sat", out_sat, es);
      chk("out_peak_u", out_peak_u, ep);
      chk("busy", busy, active);
    end
    maxc = (1 << CNT_W) - 1;
    push = 0; drop = 0; pop = 0;
    e = '{0, 0, 0};
    if (rst) begin
      q.delete();
      active = 0;
    end else begin
      pop = (q.size() > 0) && rdy;
      if (active && en) begin
        sum += spk;
        if (int'(u) > pk) pk = int'(u);
        left--;
        if (left == 0) begin
          push  = 1;
          e.cnt  = (sum > maxc) ? maxc : sum;
          e.sat  = (sum > maxc) ? 1 : 0;
          e.peak = pk;
          left = (window_len == 0) ? 1 : int'(window_len);
          sum = 0; pk = 0;
        end
      end else if (active) begin
        active = 0;
      end else if (en) begin
        active = 1;
        left = (window_len == 0) ? 1 : int'(window_len);
        sum = 0; pk = 0;
      end
      if (pop) q.delete(0);
      if (push) begin
        if (q.size() < DEPTH) q.push_back(e);
        else drop = 1;
      end
    end
    if (chk_on) chk("drop_pulse", drop_pulse, drop);
    if (drop_pulse === 1'b1) drops_seen++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 0, 1);
  endtask

  initial begin
    int d0;
    bit pat [10];
    logic [2:0] useq [4];
    reset = 1; spike_in = 0; u_in = 0; enable = 0; out_ready = 0; window_len = 4;
    @(negedge clk);
    cycle(1, 0, 3'd0, 0, 0);
    chk_on = 1;
    cycle(1, 0, 3'd0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_busy", busy, 0);

    // Back-to-back 4-cycle windows, spikes in cycles 1 and 3
    window_len = 4;
    cycle(0, 0, 3'd0, 1, 0);
    cycle(0, 1, 3'd0, 1, 0);
    cycle(0, 0, 3'd0, 1, 0);
    cycle(0, 1, 3'd0, 1, 0);
    cycle(0, 0, 3'd0, 1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", out_count, 2);
    chk("t1_sat", out_sat, 0);
    chk("t1_nogap_busy", busy, 1);
    cycle(0, 1, 3'd0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 3'd0, 1, 0);
    chk("t1_w2_count", out_count, 4);
    idle(3);

    // Saturation over a 20-cycle window with a 4-bit counter
    window_len = 20;
    cycle(0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 3'd0, 1, 0);
    chk("t2_count", out_count, 15);
    chk("t2_sat", out_sat, 1);
    cycle(0, 0, 3'd0, 1, 1);
    for (int i = 0; i < 19; i++) cycle(0, 0, 3'd0, 1, 0);
    chk("t2_next_valid", out_valid, 1);
    chk("t2_next_count", out_count, 0);
    chk("t2_next_sat", out_sat, 0);
    idle(3);

    // Fill, overflow once, drain in order
    pat = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1};
    d0 = drops_seen;
    window_len = 2;
    cycle(0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, pat[i], 3'd0, 1, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_count, 0);
    chk("t3_drops", drops_seen - d0, 1);
    idle(4);
    chk("t3_empty", out_valid, 0);

    // Full FIFO with a pop on the push cycle: no drop, occupancy stays full
    d0 = drops_seen;
    cycle(0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'd0, 1, 0);
    cycle(0, 0, 3'd0, 1, 0);
    cycle(0, 0, 3'd0, 1, 1);
    chk("t4_nodrop", drops_seen - d0, 0);
    cycle(0, 0, 3'd0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 3'd0, 0, 1);
    chk("t4_occ_after3", out_valid, 1);
    cycle(0, 0, 3'd0, 0, 1);
    chk("t4_occ_after4", out_valid, 0);

    // Abandon mid-window, then reset with entries queued
    window_len = 4;
    cycle(0, 0, 3'd0, 1, 0);
    cycle(0, 1, 3'd0, 1, 0);
    cycle(0, 1, 3'd0, 0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_noentry", out_valid, 0);
    window_len = 2;
    cycle(0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 3'd0, 1, 0);
    chk("t5_queued", out_valid, 1);
    cycle(1, 0, 3'd0, 1, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);

    // Peak membrane potential
    useq = '{3'd1, 3'd6, 3'd3, 3'd2};
    window_len = 4;
    cycle(0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, useq[i], 1, 0);
`ifdef PEAK_U_EN
    chk("t6_peak", out_peak_u, 6);
`else
    chk("t6_peak", out_peak_u, 0);
`endif
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) window_len = WIN_W'($urandom_range(0, 5));
      cycle($urandom_range(0, 199) == 0, 1'($urandom), 3'($urandom), $urandom_range(0, 7) != 0,
            $urandom_range(0, 2) == 0);
    end
    idle(8);
    chk("final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
